// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and FSM encoding for the TDM demux
package tdm_pkg;

  localparam int N     = 16;
  localparam int SEL_W = $clog2(N);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-N slot counter with load-to-1, clear and terminal count
module tdm_slot_counter #(
  parameter  int N     = tdm_pkg::N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);
  import tdm_pkg::*;

  assign tc = (cnt == SEL_W'(N - 1));

  // clear beats load beats increment; increment at terminal count wraps to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SEL_W'(1);
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to16_tdm.sv
// rtl/demux_1to16_tdm.sv - 1-to-N TDM deserializer with slot select, frame valid and abort pulses
module demux_1to16_tdm #(
  parameter  int N     = tdm_pkg::N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err
);
  import tdm_pkg::*;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           cnt_inc, cnt_load1, cnt_tc;

  tdm_slot_counter #(.N(N)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (1'b0),
    .cnt   (sel),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    if (din_valid) begin
      case (state_q)
        IDLE: begin
          // bits arriving outside a frame are silently dropped
          if (frame_start) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            err_d       = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
          end else if (cnt_tc) begin
            dout_d  = {din, shadow_q[N-2:0]};
            valid_d = 1'b1;
            cnt_inc = 1'b1;
            state_d = IDLE;
          end else begin
            shadow_d[sel] = din;
            cnt_inc       = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_demux_1to16_tdm.sv
// tb/tb_demux_1to16_tdm.sv - self-checking bench for demux_1to16_tdm
module tb_demux_1to16_tdm;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din, din_valid, frame_start;
  logic [3:0]   sel;
  logic [N-1:0] dout;
  logic         dout_valid, busy, frame_err;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  // reference model: bits of the frame in progress, in arrival order
  logic         q[$];
  logic         in_frame;
  logic [N-1:0] m_dout;
  logic         m_valid, m_err;

  int           vcyc[$];
  logic [N-1:0] vval[$];
  int           nerr;

  always #5 clk = ~clk;

  demux_1to16_tdm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .sel         (sel),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    m_dout   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel"},   32'(sel),        in_frame ? 32'(q.size()) : 32'd0);
    check({tag, ".dout"},  32'(dout),       32'(m_dout));
    check({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".err"},   32'(frame_err),  32'(m_err));
    check({tag, ".busy"},  32'(busy),       32'(in_frame));
  endtask

  task automatic step(input string tag, input logic v, input logic fs, input logic d);
    @(negedge clk);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    cyc++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (fs) begin
        if (in_frame) m_err = 1'b1;
        q.delete();
        q.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        q.push_back(d);
        if (q.size() == N) begin
          for (int i = 0; i < N; i++) m_dout[i] = q[i];
          m_valid  = 1'b1;
          in_frame = 1'b0;
          q.delete();
        end
      end
    end
    #1;
    if (dout_valid === 1'b1) begin
      vcyc.push_back(cyc);
      vval.push_back(dout);
    end
    if (frame_err === 1'b1) nerr++;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [N-1:0] w, input int stall_a, input int stall_b);
    for (int i = 0; i < N; i++) begin
      step(tag, 1'b1, i == 0, w[i]);
      if (i == stall_a || i == stall_b)
        for (int s = 0; s < 3; s++) step({tag, ".stall"}, 1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic clear_logs();
    vcyc.delete();
    vval.delete();
    nerr = 0;
  endtask

  initial begin
    model_reset();
    clear_logs();
    rst_n = 1'b0;
    din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // a..p = 0,1,0,0,1,1,0,1,0,1,0,0,1,0,0,0
    clear_logs();
    send_frame("full", 16'h12B2, -1, -1);
    step("full.after", 1'b0, 1'b0, 1'b0);
    check("full.pulses", 32'(vcyc.size()), 32'd1);
    check("full.dout", 32'(dout), 32'h12B2);

    clear_logs();
    send_frame("stall", 16'h12B2, 4, 11);
    check("stall.pulses", 32'(vcyc.size()), 32'd1);
    check("stall.dout", 32'(dout), 32'h12B2);

    clear_logs();
    for (int i = 0; i < 7; i++) step("early.part", 1'b1, i == 0, 1'b0);
    send_frame("early", 16'hFFFF, -1, -1);
    check("early.errs", 32'(nerr), 32'd1);
    check("early.pulses", 32'(vcyc.size()), 32'd1);
    check("early.dout", 32'(dout), 32'hFFFF);

    clear_logs();
    send_frame("b2b.a", 16'hA5A5, -1, -1);
    send_frame("b2b.b", 16'h5A5A, -1, -1);
    check("b2b.pulses", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) begin
      check("b2b.spacing", 32'(vcyc[1] - vcyc[0]), 32'd16);
      check("b2b.first", 32'(vval[0]), 32'hA5A5);
      check("b2b.second", 32'(vval[1]), 32'h5A5A);
    end

    clear_logs();
    for (int i = 0; i < 5; i++) step("idle", 1'b1, 1'b0, 1'($urandom));
    check("idle.pulses", 32'(vcyc.size() + nerr), 32'd0);

    // reset in the middle of a frame, checked before any clock edge
    for (int i = 0; i < 9; i++) step("midrst.part", 1'b1, i == 0, 1'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
